// File: rtl/viterbi_pkg.sv
// Shared types and default sizing for the Viterbi BER checker.
package viterbi_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      LOCKED = 2'd2
   } ber_state_t;

   localparam int BER_MAX_LAT  = 64;
   localparam int BER_SYNC_LEN = 32;
   localparam int BER_WIN      = 64;
   localparam int BER_LOSS_THR = 8;
   localparam int BER_CW       = 32;

endpackage

// File: rtl/viterbi_ber_checker_if.sv
// Stream and status bundle between the test harness and the BER checker.
interface viterbi_ber_checker_if #(
   parameter int MAX_LAT = 64,
   parameter int CW      = 32
);
   localparam int LW = $clog2(MAX_LAT);

   logic          ref_valid_i;
   logic          ref_bit_i;
   logic          dec_valid_i;
   logic          dec_bit_i;
   logic          clear_i;
   logic          locked_o;
   logic [LW-1:0] latency_o;
   logic [CW-1:0] bit_ct_o;
   logic [CW-1:0] err_ct_o;
   logic          err_o;

   modport master (
      output ref_valid_i, ref_bit_i, dec_valid_i, dec_bit_i, clear_i,
      input  locked_o, latency_o, bit_ct_o, err_ct_o, err_o
   );

   modport slave (
      input  ref_valid_i, ref_bit_i, dec_valid_i, dec_bit_i, clear_i,
      output locked_o, latency_o, bit_ct_o, err_ct_o, err_o
   );
endinterface

// File: rtl/viterbi_ref_hist.sv
// Reference-bit history: newest bit at index 0, fill count tells which taps hold real data.
module viterbi_ref_hist #(
   parameter int MAX_LAT = 64,
   parameter int LW      = $clog2(MAX_LAT)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          shift_en,
   input  logic          bit_in,
   input  logic [LW-1:0] rd_idx,
   output logic          rd_bit,
   output logic          rd_ok
);
   localparam int FW = $clog2(MAX_LAT + 1);

   logic [MAX_LAT-1:0] hist_r;
   logic [FW-1:0]      fill_r;

   // Shift in each valid reference bit and count fill up to the history depth.
   always_ff @(posedge clk) begin
      if (rst) begin
         hist_r <= '0;
         fill_r <= '0;
      end else if (shift_en) begin
         hist_r <= {hist_r[MAX_LAT-2:0], bit_in};
         if (fill_r != FW'(MAX_LAT)) begin
            fill_r <= fill_r + 1'b1;
         end
      end
   end

   // Read taps come from pre-shift state so latency 0 is the previous ref bit.
   assign rd_bit = hist_r[rd_idx];
   assign rd_ok  = (fill_r > FW'(rd_idx));

endmodule

// File: rtl/viterbi_ber_checker.sv
// Latency-searching BER checker: correlates decoded bits against the reference
// history, locks to the decoder latency, then counts compared bits and errors.
module viterbi_ber_checker
   import viterbi_pkg::*;
#(
   parameter int MAX_LAT  = BER_MAX_LAT,
   parameter int SYNC_LEN = BER_SYNC_LEN,
   parameter int WIN      = BER_WIN,
   parameter int LOSS_THR = BER_LOSS_THR,
   parameter int CW       = BER_CW
) (
   input logic                   clk,
   input logic                   rst,
   viterbi_ber_checker_if.slave  bus
);
   localparam int LW = $clog2(MAX_LAT);
   localparam int MW = $clog2(SYNC_LEN + 1);
   localparam int WW = $clog2(WIN + 1);

   ber_state_t    state_r;
   logic [LW-1:0] cand_r;
   logic [LW-1:0] latency_r;
   logic [MW-1:0] match_ct_r;
   logic [WW-1:0] win_cnt_r;
   logic [WW-1:0] win_err_r;
   logic [CW-1:0] bit_ct_r;
   logic [CW-1:0] err_ct_r;
   logic          locked_r;
   logic          err_r;

   logic [LW-1:0] rd_idx_s;
   logic          hist_bit_s;
   logic          hist_ok_s;
   logic          mismatch_s;
   logic          win_end_s;
   logic [WW-1:0] win_err_nx_s;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == {CW{1'b1}}) ? v : v + 1'b1;
   endfunction

   // While locked read the locked tap, otherwise the candidate under test.
   always_comb begin
      if (state_r == LOCKED) begin
         rd_idx_s = latency_r;
      end else begin
         rd_idx_s = cand_r;
      end
   end

   viterbi_ref_hist #(.MAX_LAT(MAX_LAT), .LW(LW)) u_hist (
      .clk      (clk),
      .rst      (rst),
      .shift_en (bus.ref_valid_i),
      .bit_in   (bus.ref_bit_i),
      .rd_idx   (rd_idx_s),
      .rd_bit   (hist_bit_s),
      .rd_ok    (hist_ok_s)
   );

   // Compare result and window bookkeeping for the current decoded sample.
   always_comb begin
      mismatch_s = bus.dec_bit_i ^ hist_bit_s;
      win_end_s  = (win_cnt_r == WW'(WIN - 1));
      if (mismatch_s && (win_err_r != {WW{1'b1}})) begin
         win_err_nx_s = win_err_r + 1'b1;
      end else begin
         win_err_nx_s = win_err_r;
      end
   end

   // Search / lock state machine, including the loss-of-lock window monitor.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         cand_r     <= '0;
         latency_r  <= '0;
         match_ct_r <= '0;
         win_cnt_r  <= '0;
         win_err_r  <= '0;
         locked_r   <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         err_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.ref_valid_i) begin
                  state_r <= SEARCH;
               end
            end
            SEARCH: begin
               if (bus.dec_valid_i && hist_ok_s) begin
                  if (!mismatch_s) begin
                     if (match_ct_r == MW'(SYNC_LEN - 1)) begin
                        state_r    <= LOCKED;
                        latency_r  <= cand_r;
                        locked_r   <= 1'b1;
                        match_ct_r <= '0;
                        win_cnt_r  <= '0;
                        win_err_r  <= '0;
                     end else begin
                        match_ct_r <= match_ct_r + 1'b1;
                     end
                  end else begin
                     match_ct_r <= '0;
                     cand_r     <= (cand_r == LW'(MAX_LAT - 1)) ? '0 : cand_r + 1'b1;
                  end
               end
            end
            LOCKED: begin
               if (bus.dec_valid_i) begin
                  err_r <= mismatch_s;
                  if (win_end_s) begin
                     win_cnt_r <= '0;
                     win_err_r <= '0;
                     if (win_err_nx_s >= WW'(LOSS_THR)) begin
                        state_r    <= SEARCH;
                        locked_r   <= 1'b0;
                        cand_r     <= '0;
                        match_ct_r <= '0;
                     end
                  end else begin
                     win_cnt_r <= win_cnt_r + 1'b1;
                     win_err_r <= win_err_nx_s;
                  end
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   // BER counters: clear wins over a same-cycle increment, values held outside lock.
   always_ff @(posedge clk) begin
      if (rst || bus.clear_i) begin
         bit_ct_r <= '0;
         err_ct_r <= '0;
      end else if ((state_r == LOCKED) && bus.dec_valid_i) begin
         bit_ct_r <= sat_inc(bit_ct_r);
         if (mismatch_s) begin
            err_ct_r <= sat_inc(err_ct_r);
         end
      end
   end

   assign bus.locked_o  = locked_r;
   assign bus.latency_o = latency_r;
   assign bus.bit_ct_o  = bit_ct_r;
   assign bus.err_ct_o  = err_ct_r;
   assign bus.err_o     = err_r;

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Directed bench for viterbi_ber_checker: PRBS7 reference, delayed copy as decoder output.
module tb_viterbi_ber_checker;
   import viterbi_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   viterbi_ber_checker_if #(.MAX_LAT(64), .CW(32)) bus ();

   viterbi_ber_checker #(
      .MAX_LAT(64), .SYNC_LEN(32), .WIN(64), .LOSS_THR(8), .CW(32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int           n_chk  = 0;
   int           n_pass = 0;
   logic [6:0]   lfsr   = 7'h7F;
   logic [127:0] tb_hist = '0;
   int           dly    = 10;
   int           pulses = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One sample: next PRBS ref bit, decoded bit = ref history tap dly (optionally inverted).
   task automatic drive(input logic inj, input logic clr);
      logic b;
      b = lfsr[6] ^ lfsr[5];
      lfsr = {lfsr[5:0], b};
      bus.ref_valid_i = 1'b1;
      bus.ref_bit_i   = b;
      bus.dec_valid_i = 1'b1;
      bus.dec_bit_i   = tb_hist[dly] ^ inj;
      bus.clear_i     = clr;
      tick();
      tb_hist = {tb_hist[126:0], b};
      bus.clear_i = 1'b0;
      if (bus.err_o) pulses++;
   endtask

   task automatic wait_lock(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (bus.locked_o) break;
         drive(1'b0, 1'b0);
      end
   endtask

   initial begin
      int fall_at;
      int seen;
      int bc0;

      rst = 1'b1;
      bus.ref_valid_i = 1'b0;
      bus.ref_bit_i   = 1'b0;
      bus.dec_valid_i = 1'b0;
      bus.dec_bit_i   = 1'b0;
      bus.clear_i     = 1'b0;
      repeat (3) tick();
      check("rst_locked",  32'(bus.locked_o),  32'd0);
      check("rst_latency", 32'(bus.latency_o), 32'd0);
      check("rst_bit_ct",  bus.bit_ct_o,       32'd0);
      check("rst_err_ct",  bus.err_ct_o,       32'd0);
      check("rst_err",     32'(bus.err_o),     32'd0);
      rst = 1'b0;

      // Error-free lock at latency 10
      dly = 10;
      wait_lock(2000);
      check("lock_seen",    32'(bus.locked_o),  32'd1);
      check("lock_latency", 32'(bus.latency_o), 32'd10);
      check("lock_bit_ct",  bus.bit_ct_o,       32'd0);
      repeat (20) drive(1'b0, 1'b0);
      check("run_bit_ct", bus.bit_ct_o, 32'd20);
      check("run_err_ct", bus.err_ct_o, 32'd0);

      // Clear colliding with a mismatch
      pulses = 0;
      drive(1'b1, 1'b1);
      check("clr_bit_ct", bus.bit_ct_o,       32'd0);
      check("clr_err_ct", bus.err_ct_o,       32'd0);
      check("clr_err",    32'(bus.err_o),     32'd1);
      check("clr_locked", 32'(bus.locked_o),  32'd1);
      drive(1'b0, 1'b0);
      check("post_clr_bit_ct", bus.bit_ct_o,   32'd1);
      check("post_clr_err",    32'(bus.err_o), 32'd0);

      // Sparse errors: every 16th of 256 samples
      drive(1'b0, 1'b1);
      check("sparse_start", bus.bit_ct_o, 32'd0);
      pulses = 0;
      for (int i = 0; i < 256; i++) drive(1'b1 & ((i % 16) == 15), 1'b0);
      check("sparse_err_ct", bus.err_ct_o,      32'd16);
      check("sparse_pulses", 32'(pulses),       32'd16);
      check("sparse_bit_ct", bus.bit_ct_o,      32'd256);
      check("sparse_locked", 32'(bus.locked_o), 32'd1);

      // Reset mid-lock, then relock at the same latency
      rst = 1'b1;
      drive(1'b0, 1'b0);
      check("mid_rst_locked",  32'(bus.locked_o),  32'd0);
      check("mid_rst_latency", 32'(bus.latency_o), 32'd0);
      check("mid_rst_bit_ct",  bus.bit_ct_o,       32'd0);
      check("mid_rst_err_ct",  bus.err_ct_o,       32'd0);
      check("mid_rst_err",     32'(bus.err_o),     32'd0);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 2000; i++) begin
         if (bus.locked_o) break;
         drive(1'b0, 1'b0);
         seen++;
      end
      check("relock_seen",    32'(bus.locked_o),  32'd1);
      check("relock_latency", 32'(bus.latency_o), 32'd10);
      check("relock_min_len", 32'(seen >= 43),    32'd1);

      // Burst errors: every 4th sample, lock drops at end of first window
      fall_at = 0;
      for (int i = 0; i < 300; i++) begin
         drive(1'b1 & ((i % 4) == 3), 1'b0);
         if (!bus.locked_o) begin
            fall_at = i + 1;
            break;
         end
      end
      check("burst_fall_at", 32'(fall_at),  32'd64);
      check("burst_bit_ct",  bus.bit_ct_o,  32'd64);
      check("burst_err_ct",  bus.err_ct_o,  32'd16);
      seen = 0;
      bc0  = 0;
      for (int i = 0; i < 200; i++) begin
         drive(1'b1 & ((i % 4) == 3), 1'b0);
         if (bus.locked_o) seen++;
         if (bus.err_o) bc0++;
      end
      check("burst_no_relock", 32'(seen),    32'd0);
      check("burst_no_pulse",  32'(bc0),     32'd0);
      check("burst_hold_bit",  bus.bit_ct_o, 32'd64);
      check("burst_hold_err",  bus.err_ct_o, 32'd16);

      // Out-of-range latency never locks
      rst = 1'b1;
      drive(1'b0, 1'b0);
      rst = 1'b0;
      dly = 70;
      seen = 0;
      for (int i = 0; i < 10000; i++) begin
         drive(1'b0, 1'b0);
         if (bus.locked_o) seen++;
      end
      check("oor_never_locked", 32'(seen),          32'd0);
      check("oor_latency",      32'(bus.latency_o), 32'd0);
      check("oor_bit_ct",       bus.bit_ct_o,       32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/viterbi_ber_checker.md
Name: viterbi_ber_checker

Overview:
- Sits directly downstream of the Viterbi decoder in the tx/rx test harness.
- Consumes the decoded bit stream and the original encoder input stream.
- Finds the decoder's end-to-end latency by correlation, locks to it, then counts decoded bits and bit errors for BER measurement across channel error-injection runs.
- Synthesizable; replaces the ad-hoc $display error accounting in the harness.

Parameters:
- MAX_LAT, 64, history depth; latencies 0..MAX_LAT-1 (in ref samples) are searchable.
- SYNC_LEN, 32, consecutive matching samples required to declare lock.
- WIN, 64, lock-monitor window length in decoded samples.
- LOSS_THR, 8, errors within one window that force loss of lock.
- CW, 32, width of bit/error counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- ref_valid_i  in  1  qualifies ref_bit_i (tie to encoder enable).
- ref_bit_i  in  1  source bit presented to the encoder.
- dec_valid_i  in  1  qualifies dec_bit_i (tie high if the decoder has no valid output).
- dec_bit_i  in  1  decoder output bit.
- clear_i  in  1  zero bit_ct_o/err_ct_o; lock unaffected.
- locked_o  out  1  latency found, counting active.
- latency_o  out  $clog2(MAX_LAT)  locked latency in ref samples.
- bit_ct_o  out  CW  decoded samples compared while locked.
- err_ct_o  out  CW  mismatches while locked.
- err_o  out  1  one-cycle pulse per counted mismatch.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high on rst. All state updates on posedge clk.
- Reset values: all outputs 0; state IDLE; history, fill counter, candidate L, match count and window counters all 0.
- History: MAX_LAT-bit shift register, hist[0] = newest. Shifts in ref_bit_i on each ref_valid_i cycle.
  - fill counter saturates at MAX_LAT; hist[k] is valid when fill > k.
  - On simultaneous ref and dec valid, compare against pre-shift history, so latency 0 means the decoded sample equals the most recent prior ref bit.
- FSM states: IDLE, SEARCH, LOCKED.
- IDLE: go to SEARCH on the first ref_valid_i.
- SEARCH, on each dec_valid_i:
  - if fill <= L: sample ignored.
  - if dec_bit_i == hist[L]: match_ct++; when match_ct reaches SYNC_LEN, go to LOCKED, latency_o <= L, locked_o <= 1 on the same edge.
  - on mismatch: match_ct <= 0; L <= L+1, wrapping MAX_LAT-1 -> 0.
  - Counters do not advance in SEARCH.
- LOCKED, on each dec_valid_i:
  - bit_ct++.
  - on mismatch with hist[latency_o]: err_ct++, win_err++, err_o = 1 on the next cycle (registered, latency 1).
  - win_cnt++; when win_cnt reaches WIN: if win_err >= LOSS_THR, go to SEARCH with locked_o <= 0, L <= 0, match_ct <= 0. Otherwise stay. Either way win_cnt and win_err are cleared.
  - bit_ct and err_ct are held across loss of lock; no counting in SEARCH.
- Width rules: bit_ct, err_ct and win_err saturate at all-ones and never wrap.
- clear_i: has priority over a same-cycle increment; both counters become 0 and that sample's error is not counted. err_o still pulses. Window state is unaffected.
- Boundaries:
  - If the true latency is >= MAX_LAT, the checker never locks, L cycles indefinitely and latency_o stays 0.
  - An all-zero ref stream locks at L=0; the bench must drive non-trivial data.
  - rst mid-lock returns every output to 0 in the next cycle.

Decomposition:
- viterbi_pkg holds:
  - typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} ber_state_t;
  - default constants BER_MAX_LAT, BER_SYNC_LEN, BER_WIN, BER_LOSS_THR.
- Sub-module viterbi_ref_hist: history shift register plus fill counter, with a read port indexed by L or latency_o.
- FSM and counters live in the top module.

Test Plan:
- Error-free lock: PRBS ref with ref_valid_i and dec_valid_i high; dec = ref delayed 10 samples, no errors -> locked_o rises, latency_o = 10, err_ct_o = 0, bit_ct_o increments once per cycle after lock.
- Sparse errors: after lock, invert dec_bit every 16th sample for 256 samples -> err_ct_o = 16, 16 err_o pulses, bit_ct_o = 256. locked_o stays 1 (4 errors per window < 8).
- Burst loss of lock: after lock, invert every 4th sample -> at the first window end (16 errors >= 8) locked_o falls. No relock while errors persist; counters hold.
- Out-of-range latency: dec delayed 70 samples with MAX_LAT = 64 -> locked_o never rises over 10000 cycles, latency_o = 0.
- Clear collision: assert clear_i in the same cycle as an injected mismatch -> bit_ct_o = err_ct_o = 0 next cycle, err_o pulses, locked_o stays 1.
- Reset mid-run: assert rst for 1 cycle while locked -> all outputs 0 next cycle. Re-lock occurs with the same latency_o after SYNC_LEN matches.
